// File: rtl/fp_int_norm.sv
// fp_int_norm: converts a signed fixed-point MAC accumulator with a shared
// exponent into an IEEE FP16 value. It normalizes serially, one left shift
// per cycle, then rounds to nearest with ties to even. Results that are too
// large saturate to the largest finite value. Results that are too small
// flush to zero, because subnormals are not produced.
module fp_int_norm #(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACC_WIDTH-1:0] fixed_point_in,
    input  logic [4:0]           exp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          fp_out,
    output logic                 ovf,
    output logic                 unf
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    typedef struct packed {
        logic [15:0] fp;
        logic        ovf;
        logic        unf;
    } result_t;

    state_t                 state;
    logic                   sign_r;
    logic [ACC_WIDTH-1:0]   mag;
    logic [4:0]             exp_r;
    logic [5:0]             lz;       // shift count; at most ACC_WIDTH-1 <= 31

    // Bits below the 10 mantissa bits: the top bit is guard, the rest are sticky.
    logic [ACC_WIDTH-12:0]  tail;
    logic [9:0]             mant;
    logic                   guard;
    logic                   sticky;
    logic [10:0]            mant_sum;
    logic signed [9:0]      exp_base;
    logic signed [9:0]      exp_fin;
    result_t                res;

    assign in_ready = (state == IDLE);

    // Round the normalized magnitude and classify the result as overflow, underflow, zero or normal.
    always_comb begin
        tail     = mag[ACC_WIDTH-12:0];
        mant     = mag[ACC_WIDTH-2 -: 10];
        guard    = tail[ACC_WIDTH-12];
        sticky   = |(tail << 1);
        mant_sum = {1'b0, mant} + {10'b0, guard & (sticky | mant[0])};
        // The biased exponent is p + exp - FRAC_BITS, where p = ACC_WIDTH-1-lz.
        exp_base = 10'(ACC_WIDTH - 1 - FRAC_BITS) - {4'b0, lz} + {5'b0, exp_r};
        exp_fin  = exp_base + (mant_sum[10] ? 10'sd1 : 10'sd0);
        res      = '0;
        if (mag == '0) begin
            res = '0;
        end else if (exp_fin >= 10'sd31) begin
            res.fp  = {sign_r, 15'h7BFF};
            res.ovf = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            res.unf = 1'b1;
        end else begin
            res.fp = {sign_r, exp_fin[4:0], mant_sum[10] ? 10'b0 : mant_sum[9:0]};
        end
    end

    // Control FSM: capture, serial normalize, round, then hold the result until it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            mag       <= '0;
            exp_r     <= '0;
            lz        <= '0;
            out_valid <= 1'b0;
            fp_out    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= fixed_point_in[ACC_WIDTH-1];
                        // The most negative input maps to 2^(ACC_WIDTH-1), which still fits unsigned.
                        mag    <= fixed_point_in[ACC_WIDTH-1] ? (~fixed_point_in + 1'b1)
                                                              : fixed_point_in;
                        exp_r  <= exp_in;
                        lz     <= '0;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0 || mag[ACC_WIDTH-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        lz  <= lz + 6'd1;
                    end
                end
                ROUND: begin
                    fp_out    <= res.fp;
                    ovf       <= res.ovf;
                    unf       <= res.unf;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
